// File: rtl/common_ram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_ram_stream_reader_pkg
// Description : Shared types and constants for the RAM stream reader and its
//               output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package common_ram_stream_reader_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Output FIFO geometry
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_PTR_W = 2;
   localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

   // Width wide enough to hold in-flight count plus FIFO occupancy
   localparam int CREDIT_W   = FIFO_CNT_W + 1;

endpackage : common_ram_stream_reader_pkg
`default_nettype wire

// File: rtl/common_stream_fifo4.sv
`default_nettype none
// ============================================================================
// Module      : common_stream_fifo4
// Description : 4-entry register FIFO with push/pop, full/empty and a
//               3-bit occupancy count. Push and pop in the same cycle keep
//               the occupancy unchanged; a push into a full FIFO is accepted
//               only when a pop frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module common_stream_fifo4
   import common_ram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  full,
   output logic                  empty,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr;
   logic [FIFO_PTR_W-1:0] rd_ptr;
   logic [FIFO_CNT_W-1:0] cnt;
   logic                  do_push;
   logic                  do_pop;

   assign empty     = (cnt == '0);
   assign full      = (cnt == FIFO_CNT_W'(FIFO_DEPTH));
   assign count     = cnt;
   assign head_data = mem[rd_ptr];
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);

   // Storage, pointers and occupancy; reset clears contents so the head reads 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + FIFO_PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + FIFO_CNT_W'(1);
            2'b01:   cnt <= cnt - FIFO_CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule : common_stream_fifo4
`default_nettype wire

// File: rtl/common_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : common_ram_stream_reader
// Description : Read-side sequencer for a simple dual-port RAM. Takes a
//               base/length command, issues RAM reads under a credit limit,
//               tracks the fixed RAM read latency and streams the returned
//               words out on a valid/ready interface with full backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module common_ram_stream_reader
   import common_ram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 9,
   parameter int RAM_LATENCY = 2,
   parameter int LEN_WIDTH   = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   issue_addr;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [LEN_WIDTH-1:0]    issue_cnt;
   logic [LEN_WIDTH-1:0]    pop_cnt;
   logic                    busy_q;
   logic                    done_q;

   // One valid bit per read travelling through the RAM pipeline
   logic [RAM_LATENCY-1:0]  inflight;
   logic [CREDIT_W-1:0]     inflight_cnt;
   logic [CREDIT_W-1:0]     occupancy;
   logic                    credit_ok;
   logic                    issue;

   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [FIFO_CNT_W-1:0]   fifo_count;
   logic [DATA_WIDTH-1:0]   fifo_head;

   // Count reads currently inside the RAM pipeline
   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
         inflight_cnt = inflight_cnt + CREDIT_W'(inflight[i]);
      end
   end

   // A word popped this cycle frees its slot immediately, which is what lets
   // the stream sustain one word per cycle. The full/pop term is redundant
   // with the sum but keeps a local guard against overflow.
   assign occupancy = inflight_cnt + CREDIT_W'(fifo_count) - CREDIT_W'(pop);
   assign credit_ok = (occupancy < CREDIT_W'(FIFO_DEPTH)) & ~(fifo_full & ~pop);
   assign issue     = (state == READ) & credit_ok;

   assign ram_re    = issue;
   assign ram_raddr = issue_addr;

   // The oldest in-flight bit lines up with valid RAM read data
   assign push      = inflight[RAM_LATENCY-1];
   assign pop       = m_valid & m_ready;

   assign m_valid   = ~fifo_empty;
   assign m_data    = fifo_head;
   assign m_last    = m_valid & (pop_cnt == (len_q - LEN_WIDTH'(1)));
   assign busy      = busy_q;
   assign done      = done_q;

   generate
      if (RAM_LATENCY == 1) begin : g_lat_one
         // Single-stage in-flight tracker for an unregistered RAM output
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               inflight <= '0;
            end else begin
               inflight <= issue;
            end
         end
      end else begin : g_lat_multi
         // Shift issued-read markers along with the RAM pipeline
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               inflight <= '0;
            end else begin
               inflight <= {inflight[RAM_LATENCY-2:0], issue};
            end
         end
      end
   endgenerate

   // Command sequencer: latch command, issue reads, wait for the last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         issue_addr <= '0;
         len_q      <= '0;
         issue_cnt  <= '0;
         pop_cnt    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (pop) begin
            pop_cnt <= pop_cnt + LEN_WIDTH'(1);
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     state      <= READ;
                     busy_q     <= 1'b1;
                     issue_addr <= base_addr;
                     len_q      <= length;
                     issue_cnt  <= '0;
                     pop_cnt    <= '0;
                  end else begin
                     // Empty command completes without producing beats
                     done_q <= 1'b1;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  issue_addr <= issue_addr + ADDR_WIDTH'(1);
                  issue_cnt  <= issue_cnt + LEN_WIDTH'(1);
                  if ((issue_cnt + LEN_WIDTH'(1)) == len_q) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   common_stream_fifo4 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (ram_rdata),
      .pop        (pop),
      .head_data  (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

endmodule : common_ram_stream_reader
`default_nettype wire

// File: tb/tb_common_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_common_ram_stream_reader
// Description : Directed bench for common_ram_stream_reader. One instance
//               with a two-cycle RAM (data = address), one with a one-cycle
//               RAM (data = inverted address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_common_ram_stream_reader;

   logic       clk;
   logic       rst_n;

   // Latency-2 instance
   logic       start;
   logic [8:0] base_addr;
   logic [9:0] length;
   logic       busy, done, ram_re, m_valid, m_ready, m_last;
   logic [8:0] ram_raddr;
   logic [7:0] ram_rdata, m_data;
   logic [7:0] ra1, ra2;

   // Latency-1 instance
   logic       b_start;
   logic [8:0] b_base_addr;
   logic [9:0] b_length;
   logic       b_busy, b_done, b_ram_re, b_m_valid, b_m_ready, b_m_last;
   logic [8:0] b_ram_raddr;
   logic [7:0] b_ram_rdata, b_m_data;
   logic [7:0] rb1;

   int total;
   int bad;

   common_ram_stream_reader #(
      .DATA_WIDTH(8), .ADDR_WIDTH(9), .RAM_LATENCY(2), .LEN_WIDTH(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .ram_re(ram_re),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   common_ram_stream_reader #(
      .DATA_WIDTH(8), .ADDR_WIDTH(9), .RAM_LATENCY(1), .LEN_WIDTH(10)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base_addr),
      .length(b_length), .busy(b_busy), .done(b_done), .ram_re(b_ram_re),
      .ram_raddr(b_ram_raddr), .ram_rdata(b_ram_rdata), .m_valid(b_m_valid),
      .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-cycle RAM: read register then output register, contents = address
   always @(posedge clk) begin
      if (ram_re) ra1 <= ram_raddr[7:0];
      ra2 <= ra1;
   end
   assign ram_rdata = ra2;

   // One-cycle RAM, contents = inverted address
   always @(posedge clk) begin
      if (b_ram_re) rb1 <= ~b_ram_raddr[7:0];
   end
   assign b_ram_rdata = rb1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
      b_start = 1'b0; b_base_addr = '0; b_length = '0; b_m_ready = 1'b1;
      #3;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (ram_re !== 1'b0) begin bad++; $display("FAIL reset_ram_re got=%b exp=0", ram_re); end
      total++; if (ram_raddr !== 9'd0) begin bad++; $display("FAIL reset_raddr got=%0d exp=0", ram_raddr); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      total++; if (m_data !== 8'd0 || m_last !== 1'b0) begin bad++; $display("FAIL reset_data_last got=%h/%b exp=00/0", m_data, m_last); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic exp_v;
      start = 1'b1; base_addr = 9'd5; length = 10'd8; m_ready = 1'b1;
      tick();
      start = 1'b0;
      total++; if (ram_re !== 1'b1 || ram_raddr !== 9'd5) begin bad++; $display("FAIL basic_first_issue got re=%b addr=%0d exp re=1 addr=5", ram_re, ram_raddr); end
      for (int c = 1; c <= 13; c++) begin
         if (c > 1) tick();
         exp_v = (c >= 4 && c <= 11);
         total++; if (m_valid !== exp_v) begin bad++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, m_valid, exp_v); end
         if (exp_v) begin
            total++; if (m_data !== 8'(c + 1) || m_last !== (c == 11)) begin bad++; $display("FAIL basic_data c=%0d got=%0d/%b exp=%0d/%b", c, m_data, m_last, c + 1, (c == 11)); end
         end
         total++; if (done !== (c == 12) || busy !== (c <= 11)) begin bad++; $display("FAIL basic_done_busy c=%0d got done=%b busy=%b", c, done, busy); end
      end
   endtask

   task automatic test_wrap();
      logic [8:0] exp_a [4];
      int iss;
      int got;
      bit seen_done;
      exp_a[0] = 9'd510; exp_a[1] = 9'd511; exp_a[2] = 9'd0; exp_a[3] = 9'd1;
      iss = 0; got = 0; seen_done = 0;
      start = 1'b1; base_addr = 9'd510; length = 10'd4; m_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         if (ram_re) begin
            total++; if (iss >= 4 || ram_raddr !== exp_a[iss]) begin bad++; $display("FAIL wrap_addr n=%0d got=%0d", iss, ram_raddr); end
            iss++;
         end
         if (m_valid && m_ready) begin
            total++; if (got >= 4 || m_data !== exp_a[got][7:0] || m_last !== (got == 3)) begin bad++; $display("FAIL wrap_data n=%0d got=%0d/%b", got, m_data, m_last); end
            got++;
         end
         if (done) seen_done = 1;
         if (!seen_done) tick();
      end
      total++; if (iss != 4 || got != 4 || !seen_done) begin bad++; $display("FAIL wrap_count got iss=%0d words=%0d done=%b exp 4/4/1", iss, got, seen_done); end
      tick();
   endtask

   task automatic test_backpressure();
      int issued;
      int acc;
      int max_out;
      bit stall;
      bit seen_done;
      logic [7:0] hold_d;
      logic hold_l;
      issued = 0; acc = 0; max_out = 0; stall = 0; seen_done = 0; hold_d = '0; hold_l = 1'b0;
      start = 1'b1; base_addr = 9'd100; length = 10'd16; m_ready = 1'b0;
      tick();
      for (int c = 1; c < 400 && !seen_done; c++) begin
         // A second command while busy must be ignored
         if (c == 6) begin start = 1'b1; base_addr = 9'd0; length = 10'd3; end
         else start = 1'b0;
         m_ready = (((c / 10) % 3) == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         if (stall) begin
            total++; if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) begin bad++; $display("FAIL bp_stable c=%0d got=%0d/%b exp=%0d/%b", c, m_data, m_last, hold_d, hold_l); end
         end
         if (ram_re) issued++;
         if (m_valid && m_ready) begin
            total++; if (acc >= 16 || m_data !== 8'(100 + acc) || m_last !== (acc == 15)) begin bad++; $display("FAIL bp_data n=%0d got=%0d/%b exp=%0d/%b", acc, m_data, m_last, 100 + acc, (acc == 15)); end
            acc++;
         end
         stall = m_valid && !m_ready;
         hold_d = m_data;
         hold_l = m_last;
         if (issued - acc > max_out) max_out = issued - acc;
         total++; if (issued - acc > 4) begin bad++; $display("FAIL bp_outstanding c=%0d got=%0d exp<=4", c, issued - acc); end
         if (done) seen_done = 1;
         tick();
      end
      start = 1'b0;
      total++; if (!seen_done || acc != 16) begin bad++; $display("FAIL bp_complete got done=%b words=%0d exp 1/16", seen_done, acc); end
      total++; if (max_out != 4) begin bad++; $display("FAIL bp_credit_peak got=%0d exp=4", max_out); end
      total++; if (busy !== 1'b0 || m_valid !== 1'b0 || ram_re !== 1'b0) begin bad++; $display("FAIL bp_ignored_start got busy=%b valid=%b re=%b exp 0/0/0", busy, m_valid, ram_re); end
      m_ready = 1'b1;
   endtask

   task automatic test_len0();
      start = 1'b1; base_addr = 9'd7; length = 10'd0;
      tick();
      start = 1'b0;
      total++; if (done !== 1'b1 || busy !== 1'b0 || ram_re !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL len0_t1 got done=%b busy=%b re=%b valid=%b exp 1/0/0/0", done, busy, ram_re, m_valid); end
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0 || ram_re !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL len0_t2 got done=%b busy=%b re=%b valid=%b exp 0/0/0/0", done, busy, ram_re, m_valid); end
   endtask

   task automatic test_reset_mid();
      int acc;
      bit seen_done;
      acc = 0; seen_done = 0;
      start = 1'b1; base_addr = 9'd20; length = 10'd8; m_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 30 && acc < 3; c++) begin
         if (m_valid && m_ready) acc++;
         if (acc < 3) tick();
      end
      rst_n = 1'b0;
      #1;
      total++; if (acc != 3) begin bad++; $display("FAIL rstmid_progress got=%0d exp=3", acc); end
      total++; if (busy !== 1'b0 || done !== 1'b0 || ram_re !== 1'b0 || ram_raddr !== 9'd0) begin bad++; $display("FAIL rstmid_ctrl got busy=%b done=%b re=%b addr=%0d exp 0", busy, done, ram_re, ram_raddr); end
      total++; if (m_valid !== 1'b0 || m_data !== 8'd0 || m_last !== 1'b0) begin bad++; $display("FAIL rstmid_stream got valid=%b data=%0d last=%b exp 0", m_valid, m_data, m_last); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      start = 1'b1; base_addr = 9'd40; length = 10'd3;
      tick();
      start = 1'b0;
      acc = 0;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         if (m_valid && m_ready) begin
            total++; if (acc >= 3 || m_data !== 8'(40 + acc) || m_last !== (acc == 2)) begin bad++; $display("FAIL rstmid_clean n=%0d got=%0d/%b exp=%0d/%b", acc, m_data, m_last, 40 + acc, (acc == 2)); end
            acc++;
         end
         if (done) seen_done = 1;
         if (!seen_done) tick();
      end
      total++; if (acc != 3 || !seen_done) begin bad++; $display("FAIL rstmid_count got words=%0d done=%b exp 3/1", acc, seen_done); end
      tick();
   endtask

   task automatic test_lat1();
      b_start = 1'b1; b_base_addr = 9'd0; b_length = 10'd1; b_m_ready = 1'b1;
      tick();
      b_start = 1'b0;
      total++; if (b_ram_re !== 1'b1 || b_ram_raddr !== 9'd0 || b_busy !== 1'b1) begin bad++; $display("FAIL lat1_issue got re=%b addr=%0d busy=%b exp 1/0/1", b_ram_re, b_ram_raddr, b_busy); end
      tick();
      total++; if (b_m_valid !== 1'b0) begin bad++; $display("FAIL lat1_early_valid got=%b exp=0", b_m_valid); end
      tick();
      total++; if (b_m_valid !== 1'b1 || b_m_data !== 8'hFF || b_m_last !== 1'b1 || b_done !== 1'b0) begin bad++; $display("FAIL lat1_word got valid=%b data=%h last=%b done=%b exp 1/ff/1/0", b_m_valid, b_m_data, b_m_last, b_done); end
      tick();
      total++; if (b_done !== 1'b1 || b_busy !== 1'b0 || b_m_valid !== 1'b0) begin bad++; $display("FAIL lat1_done got done=%b busy=%b valid=%b exp 1/0/0", b_done, b_busy, b_m_valid); end
      tick();
      total++; if (b_done !== 1'b0) begin bad++; $display("FAIL lat1_done_pulse got=%b exp=0", b_done); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_len0();
      test_backpressure();
      test_lat1();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_common_ram_stream_reader
`default_nettype wire
